ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 stall  in  `StallBus  pipeline stall vector; bit 2 = EX input register, bit 3 = MEM; `Stop = 1.
REQ-004 id_to_ex_bus  in  `ID_TO_EX_WD (159)  {pc, inst, alu_op[11:0], sel_alu_src1[2:0], sel_alu_src2[3:0], data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr, sel_rf_res, rdata1, rdata2}, MSB first.
REQ-005 id_load_bus  in  5  {lb, lbu, lh, lhu, lw}; id_save_bus  in  3  {sb, sh, sw}.
REQ-006 ex_to_mem_bus  out  76  {pc, data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-007 ex_load_bus  out  5  registered copy of id_load_bus.
REQ-008 ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}, forwarding to ID.
REQ-009 ex_is_load  out  1  registered instruction is any load; ID uses it for load-use stall.
REQ-010 data_sram_en / data_sram_wen[3:0] / data_sram_addr[31:0] / data_sram_wdata[31:0]  out  data-RAM request.
REQ-011 stallreq_for_ex  out  1  EX needs more cycles (divider busy).

Function
REQ-012 Input register: rst -> 0; stall[2]=Stop & stall[3]=NoStop -> 0 (bubble); stall[2]=NoStop -> load buses; otherwise hold.
REQ-013 src1 = rdata1 | pc | {27'b0, inst[10:6]} per one-hot sel_alu_src1; src2 = rdata2 | sign-ext imm | 32'd8 | zero-ext imm per sel_alu_src2.
REQ-014 ALU (one-hot alu_op): add/sub mod 2^32, slt signed, sltu unsigned, and/nor/or/xor, sll/srl/sra by src1[4:0] on src2, lui = {src2[15:0],16'b0}; no op -> 0.
REQ-015 ex_result = alu result, except mfhi/mflo (decoded from inst) -> HI/LO.
REQ-016 data_sram_en = data_ram_en | any load bit | any save bit; data_sram_addr = alu result.
REQ-017 Store byte enables: sw 4'b1111; sh addr[1]?4'b1100:4'b0011; sb 4'b0001<<addr[1:0]; non-store 0.
REQ-018 Store data: sw rdata2; sh {2{rdata2[15:0]}}; sb {4{rdata2[7:0]}}.
REQ-019 HI/LO 32-bit registers; mthi/mtlo write rdata1 when stall[2]=NoStop.
REQ-020 div (func 011010) / divu (011011), opcode 0, start divider when FSM IDLE and div_done=0.
REQ-021 Divider FSM: IDLE -> RUN (32 restoring shift-subtract iterations, counter 0..31) -> DONE -> IDLE.
REQ-022 Divisor 0: IDLE -> DONE directly; LO = 32'hFFFF_FFFF, HI = dividend.
REQ-023 Signed: operate on magnitudes; quotient negated if signs differ; remainder takes dividend sign. 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
REQ-024 stallreq_for_ex = 1 from cycle div enters EX (T) through last RUN cycle (T+32); 0 in DONE (T+33); HI<=remainder, LO<=quotient on DONE edge.
REQ-025 div_done set on DONE, cleared when EX register loads new content; prevents restart while held by downstream stall.
REQ-026 Bubble: all outputs derived from zero bus -> rf_we=0, data_sram_en=0.

Reset
REQ-027 rst clears input register, HI, LO, FSM (IDLE), counter, div_done; rst mid-division aborts it, HI/LO stay 0.
REQ-028 Post-reset outputs all 0, stallreq_for_ex = 0.

Configuration
REQ-029 Macro EX_DIV_EN: defined -> divider per REQ-020..025.
REQ-030 Undefined -> no divider logic; div/divu leave HI/LO unchanged, stallreq_for_ex tied 0.

Verification
REQ-031 addu rdata1=0xFFFFFFFF, rdata2=1 -> ex_result 0, ex_to_rf_bus we=1.
REQ-032 sb rdata1=0x1000, imm=3, rdata2=0x12345678 -> addr 0x1003, wen 4'b1000, wdata 0x78787878.
REQ-033 div -7/2 -> stall 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
REQ-034 div x/0 -> stall 1 cycle, LO=0xFFFFFFFF, HI=x.
REQ-035 rst asserted at RUN counter 10 -> next cycle IDLE, stallreq 0, HI=LO=0.
REQ-036 stall[2]=Stop, stall[3]=NoStop -> next cycle rf_we=0, data_sram_en=0; div held by stall[3]=Stop after DONE does not restart.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, HI/LO, store formatting and the data-RAM request.
// Define EX_DIV_EN to build the multi-cycle restoring divider for div/divu.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  input  logic [4:0]   id_load_bus,
  input  logic [2:0]   id_save_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [4:0]   ex_load_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         ex_is_load,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex
);

  localparam logic Stop = 1'b1;

  logic [158:0] bus_q;
  logic [4:0]   load_q;
  logic [2:0]   save_q;
  logic         ex_load, ex_bubble;

  assign ex_load   = (stall[2] != Stop);
  assign ex_bubble = (stall[2] == Stop) && (stall[3] != Stop);

  always_ff @(posedge clk) begin
    if (rst || ex_bubble) begin
      bus_q  <= '0;
      load_q <= '0;
      save_q <= '0;
    end else if (ex_load) begin
      bus_q  <= id_to_ex_bus;
      load_q <= id_load_bus;
      save_q <= id_save_bus;
    end
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res,
          rdata1, rdata2} = bus_q;

  // Selects are one-hot; an all-zero select (bubble) yields a zero operand.
  logic [31:0] src1, src2, alu_res;
  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      alu_op[11]: alu_res = src1 + src2;
      alu_op[10]: alu_res = src1 - src2;
      alu_op[9]:  alu_res = {31'b0, $signed(src1) < $signed(src2)};
      alu_op[8]:  alu_res = {31'b0, src1 < src2};
      alu_op[7]:  alu_res = src1 & src2;
      alu_op[6]:  alu_res = ~(src1 | src2);
      alu_op[5]:  alu_res = src1 | src2;
      alu_op[4]:  alu_res = src1 ^ src2;
      alu_op[3]:  alu_res = src2 << src1[4:0];
      alu_op[2]:  alu_res = src2 >> src1[4:0];
      alu_op[1]:  alu_res = 32'($signed(src2) >>> src1[4:0]);
      alu_op[0]:  alu_res = {src2[15:0], 16'b0};
      default:    alu_res = '0;
    endcase
  end

  logic special, is_mfhi, is_mflo, is_mthi, is_mtlo;
  assign special = (inst[31:26] == 6'b000000);
  assign is_mfhi = special && (inst[5:0] == 6'b010000);
  assign is_mthi = special && (inst[5:0] == 6'b010001);
  assign is_mflo = special && (inst[5:0] == 6'b010010);
  assign is_mtlo = special && (inst[5:0] == 6'b010011);

  logic [31:0] hi_q, lo_q, div_hi, div_lo, ex_result;
  logic        div_wr;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {StIdle, StRun, StDone} div_st_e;

  div_st_e     st_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        q_neg_q, r_neg_q, done_q;
  logic        is_div, is_divu, div_start, div_by_zero;
  logic [31:0] mag_a, mag_b, step_rem, step_quo, fin_quo, fin_rem;
  logic [32:0] shifted, diff;

  assign is_div      = special && (inst[5:0] == 6'b011010);
  assign is_divu     = special && (inst[5:0] == 6'b011011);
  // done_q keeps a held, already-finished div from starting over.
  assign div_start   = (st_q == StIdle) && (is_div || is_divu) && !done_q;
  assign div_by_zero = (rdata2 == 32'd0);
  assign mag_a       = (is_div && rdata1[31]) ? -rdata1 : rdata1;
  assign mag_b       = (is_div && rdata2[31]) ? -rdata2 : rdata2;

  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
  assign step_quo = {quo_q[30:0], ~diff[32]};
  assign fin_quo  = q_neg_q ? -step_quo : step_quo;
  assign fin_rem  = r_neg_q ? -step_rem : step_rem;

  assign stallreq_for_ex = div_start || (st_q == StRun);

  always_comb begin
    div_wr = 1'b0;
    div_hi = '0;
    div_lo = '0;
    if (div_start && div_by_zero) begin
      div_wr = 1'b1;
      div_hi = rdata1;
      div_lo = 32'hFFFF_FFFF;
    end else if ((st_q == StRun) && (cnt_q == 5'd31)) begin
      div_wr = 1'b1;
      div_hi = fin_rem;
      div_lo = fin_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (div_start) begin
            if (div_by_zero) begin
              st_q <= StDone;
            end else begin
              st_q    <= StRun;
              cnt_q   <= '0;
              rem_q   <= '0;
              quo_q   <= mag_a;
              dvs_q   <= mag_b;
              q_neg_q <= is_div && (rdata1[31] ^ rdata2[31]);
              r_neg_q <= is_div && rdata1[31];
            end
          end
        end
        StRun: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) st_q <= StDone;
        end
        StDone:  st_q <= StIdle;
        default: st_q <= StIdle;
      endcase
      if (ex_load || ex_bubble) done_q <= 1'b0;
      else if (st_q == StDone)  done_q <= 1'b1;
    end
  end
`else
  assign div_wr          = 1'b0;
  assign div_hi          = '0;
  assign div_lo          = '0;
  assign stallreq_for_ex = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_wr) begin
      hi_q <= div_hi;
      lo_q <= div_lo;
    end else begin
      if (is_mthi && ex_load) hi_q <= rdata1;
      if (is_mtlo && ex_load) lo_q <= rdata1;
    end
  end

  assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

  // save_q is {sb, sh, sw}; the byte lane comes from the low address bits.
  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = 32'd0;
    if (save_q[0]) begin
      data_sram_wen   = 4'b1111;
      data_sram_wdata = rdata2;
    end else if (save_q[1]) begin
      data_sram_wen   = alu_res[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{rdata2[15:0]}};
    end else if (save_q[2]) begin
      data_sram_wen   = 4'b0001 << alu_res[1:0];
      data_sram_wdata = {4{rdata2[7:0]}};
    end
  end

  assign data_sram_en   = ram_en || (|load_q) || (|save_q);
  assign data_sram_addr = alu_res;
  assign ex_load_bus    = load_q;
  assign ex_is_load     = |load_q;
  assign ex_to_mem_bus  = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus   = {rf_we, rf_waddr, ex_result};

  logic unused_ok;
  assign unused_ok = ^{stall[5:4], stall[1:0], inst[25:16]};

endmodule
